// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable width, parity and stop bits.
// Samples each bit at mid-bit; reports framing/parity errors with data_valid.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int              CW         = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CNT_HALF   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST  = 4'(STOP_BITS - 1);
  localparam logic            ODD        = 1'(PARITY_ODD);
  localparam logic            HAS_PARITY = (PARITY_EN != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t               state;
  logic [CW-1:0]        ccnt;
  logic [3:0]           bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 fbad;
  logic                 par_bad;
  logic                 sync1;
  logic                 rx_s;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    data_valid <= 1'b0;
    if (reset) begin
      state      <= IDLE;
      ccnt       <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      fbad       <= 1'b0;
      par_bad    <= 1'b0;
      busy       <= 1'b0;
      data_out   <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else if (!en) begin
      state <= IDLE;
      ccnt  <= '0;
      bcnt  <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          ccnt <= '0;
          bcnt <= '0;
          if (!rx_s) begin
            state   <= START;
            busy    <= 1'b1;
            fbad    <= 1'b0;
            par_bad <= 1'b0;
          end
        end
        // A start bit that is high again at mid-bit was only a glitch.
        START: begin
          if (ccnt == CNT_HALF) begin
            ccnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
              bcnt  <= '0;
            end
          end else begin
            ccnt <= ccnt + 1'b1;
          end
        end
        DATA: begin
          if (ccnt == CNT_LAST) begin
            ccnt  <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bcnt == DATA_LAST) begin
              bcnt  <= '0;
              state <= HAS_PARITY ? PARITY : STOP;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end else begin
            ccnt <= ccnt + 1'b1;
          end
        end
        PARITY: begin
          if (ccnt == CNT_LAST) begin
            ccnt    <= '0;
            par_bad <= ((^shreg) ^ rx_s) != ODD;
            state   <= STOP;
          end else begin
            ccnt <= ccnt + 1'b1;
          end
        end
        // The frame is delivered on the edge after the last stop sample, so the
        // receiver is already back in IDLE for a zero-gap next start bit.
        STOP: begin
          if (ccnt == CNT_LAST) begin
            ccnt <= '0;
            if (bcnt == STOP_LAST) begin
              bcnt       <= '0;
              data_valid <= 1'b1;
              data_out   <= shreg;
              frame_err  <= fbad | ~rx_s;
              parity_err <= par_bad;
              busy       <= 1'b0;
              state      <= (fbad | ~rx_s) ? BREAK : IDLE;
            end else begin
              bcnt <= bcnt + 1'b1;
              fbad <= fbad | ~rx_s;
            end
          end else begin
            ccnt <= ccnt + 1'b1;
          end
        end
        // A line held low after a bad frame is a break: report it once only.
        BREAK: begin
          busy <= 1'b0;
          ccnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: 8N1, 7E1 and 8N2 instances driven one at a time,
// strobes scored against a queue of frames pushed when they are sent.
module tb_uart_rx_param;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       rx_line;
  int         sel;
  logic       rx0, rx1, rx2;

  logic [7:0] data_out0, data_out2;
  logic [6:0] data_out1;
  logic       dv0, dv1, dv2;
  logic       busy0, busy1, busy2;
  logic       fe0, fe1, fe2;
  logic       pe0, pe1, pe2;

  assign rx0 = (sel == 0) ? rx_line : 1'b1;
  assign rx1 = (sel == 1) ? rx_line : 1'b1;
  assign rx2 = (sel == 2) ? rx_line : 1'b1;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .en(en), .rx_in(rx0), .data_out(data_out0),
    .data_valid(dv0), .busy(busy0), .frame_err(fe0), .parity_err(pe0));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_7e1 (
    .clk(clk), .reset(reset), .en(en), .rx_in(rx1), .data_out(data_out1),
    .data_valid(dv1), .busy(busy1), .frame_err(fe1), .parity_err(pe1));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .reset(reset), .en(en), .rx_in(rx2), .data_out(data_out2),
    .data_valid(dv2), .busy(busy2), .frame_err(fe2), .parity_err(pe2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         dut;
    logic [8:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   dv_count    = 0;
  int   last_dv_cyc = -1;
  int   rise_cyc    = -1;
  int   fall_cyc    = -1;
  int   start_cyc   = 0;
  int   cnt_before  = 0;
  logic busy_prev   = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, observed, expected);
    end
  endtask

  task automatic score_strobe(input int d, input logic [8:0] data, input logic fe, input logic pe);
    exp_t e;
    dv_count++;
    last_dv_cyc = cyc;
    checkOutput("strobe_expected", 32'(sbq.size() != 0), 1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      checkOutput("sb_dut", d, e.dut);
      checkOutput("sb_data", 32'(data), 32'(e.data));
      checkOutput("sb_frame_err", 32'(fe), 32'(e.fe));
      checkOutput("sb_parity_err", 32'(pe), 32'(e.pe));
    end
  endtask

  // Strobe scoring and busy edge timestamps, sampled mid-cycle.
  always @(negedge clk) begin
    if (dv0) score_strobe(0, {1'b0, data_out0}, fe0, pe0);
    if (dv1) score_strobe(1, {2'b0, data_out1}, fe1, pe1);
    if (dv2) score_strobe(2, {1'b0, data_out2}, fe2, pe2);
    if (busy0 && !busy_prev) rise_cyc = cyc;
    if (!busy0 && busy_prev) fall_cyc = cyc;
    busy_prev = busy0;
  end

  task automatic expect_frame(input int d, input logic [8:0] data, input logic fe, input logic pe);
    exp_t e;
    e.dut  = d;
    e.data = data;
    e.fe   = fe;
    e.pe   = pe;
    sbq.push_back(e);
  endtask

  // Called and returns 1 time unit after a rising edge.
  task automatic drive_bit(input logic v, input int n);
    rx_line = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [8:0] data, input int nbits, input int par,
                               input int nstop, input logic stop_val);
    start_cyc = cyc;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < nbits; i++) drive_bit(data[i], CPB);
    if (par >= 0) drive_bit(par[0], CPB);
    for (int i = 0; i < nstop; i++) drive_bit(stop_val, CPB);
  endtask

  // Start of an 0xF0 frame, stopping halfway through data bit 4 (line high).
  task automatic partial_frame();
    drive_bit(1'b0, CPB);
    drive_bit(1'b0, 4 * CPB);
    drive_bit(1'b1, CPB / 2);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sel     = 0;
    rx_line = 1'b1;
    en      = 1'b1;
    reset   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    checkOutput("reset_data_out", 32'(data_out0), 0);
    checkOutput("reset_data_valid", 32'(dv0), 0);
    checkOutput("reset_busy", 32'(busy0), 0);
    checkOutput("reset_frame_err", 32'(fe0), 0);
    checkOutput("reset_parity_err", 32'(pe0), 0);
    drive_bit(1'b1, 20);

    // 8N1 0xA5: strobe 153 cycles after rx_s falls, 2 more for the synchroniser.
    expect_frame(0, 9'h0A5, 1'b0, 1'b0);
    applyStimulus(9'h0A5, 8, -1, 1, 1'b1);
    drive_bit(1'b1, CPB);
    checkOutput("a5_latency", last_dv_cyc - start_cyc, 155);
    checkOutput("a5_busy_rise", rise_cyc - start_cyc, 3);
    checkOutput("a5_busy_fall", fall_cyc - start_cyc, 155);
    checkOutput("a5_data_hold", 32'(data_out0), 'hA5);

    // Glitch start bit of 4 cycles.
    cnt_before = dv_count;
    start_cyc  = cyc;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 40);
    checkOutput("glitch_busy_rise", rise_cyc - start_cyc, 3);
    checkOutput("glitch_busy_fall", fall_cyc - start_cyc, 11);
    checkOutput("glitch_no_strobe", dv_count - cnt_before, 0);
    checkOutput("glitch_idle_busy", 32'(busy0), 0);
    expect_frame(0, 9'h05A, 1'b0, 1'b0);
    applyStimulus(9'h05A, 8, -1, 1, 1'b1);
    drive_bit(1'b1, CPB);

    // Bad stop bit followed by a 40 bit-time break.
    cnt_before = dv_count;
    expect_frame(0, 9'h03C, 1'b1, 1'b0);
    applyStimulus(9'h03C, 8, -1, 1, 1'b0);
    drive_bit(1'b0, 40 * CPB);
    checkOutput("break_one_strobe", dv_count - cnt_before, 1);
    checkOutput("break_busy", 32'(busy0), 0);
    checkOutput("break_fe_hold", 32'(fe0), 1);
    drive_bit(1'b1, 2 * CPB);
    expect_frame(0, 9'h0C3, 1'b0, 1'b0);
    applyStimulus(9'h0C3, 8, -1, 1, 1'b1);
    drive_bit(1'b1, CPB);
    checkOutput("break_recover_count", dv_count - cnt_before, 2);
    checkOutput("break_fe_cleared", 32'(fe0), 0);

    // Abort with en low mid data bit 4.
    cnt_before = dv_count;
    partial_frame();
    en = 1'b0;
    drive_bit(1'b1, 1);
    checkOutput("abort_en_busy", 32'(busy0), 0);
    checkOutput("abort_en_data_hold", 32'(data_out0), 'hC3);
    en = 1'b1;
    drive_bit(1'b1, 6 * CPB);
    expect_frame(0, 9'h012, 1'b0, 1'b0);
    applyStimulus(9'h012, 8, -1, 1, 1'b1);
    drive_bit(1'b1, CPB);
    checkOutput("abort_en_count", dv_count - cnt_before, 1);

    // Abort with reset mid-frame.
    partial_frame();
    reset = 1'b1;
    drive_bit(1'b1, 1);
    reset = 1'b0;
    checkOutput("abort_rst_data_out", 32'(data_out0), 0);
    checkOutput("abort_rst_data_valid", 32'(dv0), 0);
    checkOutput("abort_rst_busy", 32'(busy0), 0);
    checkOutput("abort_rst_frame_err", 32'(fe0), 0);
    checkOutput("abort_rst_parity_err", 32'(pe0), 0);
    drive_bit(1'b1, 6 * CPB);
    expect_frame(0, 9'h012, 1'b0, 1'b0);
    applyStimulus(9'h012, 8, -1, 1, 1'b1);
    drive_bit(1'b1, CPB);

    // 7E1: good parity, bad parity, good parity with odd data weight.
    sel = 1;
    drive_bit(1'b1, CPB);
    expect_frame(1, 9'h041, 1'b0, 1'b0);
    applyStimulus(9'h041, 7, 0, 1, 1'b1);
    expect_frame(1, 9'h041, 1'b0, 1'b1);
    applyStimulus(9'h041, 7, 1, 1, 1'b1);
    expect_frame(1, 9'h07F, 1'b0, 1'b0);
    applyStimulus(9'h07F, 7, 1, 1, 1'b1);
    drive_bit(1'b1, CPB);

    // 8N2: three zero-gap frames.
    sel = 2;
    drive_bit(1'b1, CPB);
    cnt_before = dv_count;
    expect_frame(2, 9'h000, 1'b0, 1'b0);
    applyStimulus(9'h000, 8, -1, 2, 1'b1);
    expect_frame(2, 9'h0FF, 1'b0, 1'b0);
    applyStimulus(9'h0FF, 8, -1, 2, 1'b1);
    expect_frame(2, 9'h055, 1'b0, 1'b0);
    applyStimulus(9'h055, 8, -1, 2, 1'b1);
    drive_bit(1'b1, CPB);
    checkOutput("8n2_latency", last_dv_cyc - start_cyc, 171);
    checkOutput("8n2_count", dv_count - cnt_before, 3);

    checkOutput("sb_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
